// File: rtl/hold_repeat_ctrl_pkg.sv
// Shared encodings and default timing constants for the hold-to-repeat controller.
// Tick constants assume a 10 ms tick.
package hold_repeat_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_INITIAL = 2'd1,
        ST_REPEAT  = 2'd2,
        ST_FAST    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_SEC  = 2'd1,
        OWN_MIN  = 2'd2
    } owner_t;

    localparam int DEF_INITIAL_DELAY_TICKS = 50;
    localparam int DEF_REPEAT_TICKS        = 20;
    localparam int DEF_FAST_AFTER          = 10;
    localparam int DEF_FAST_TICKS          = 5;
    localparam int DEF_CTR_WIDTH           = 8;

    // Level of the request belonging to the current owner; no owner means no request.
    function automatic logic owner_request(input owner_t owner, input logic sec, input logic min);
        case (owner)
            OWN_SEC: return sec;
            OWN_MIN: return min;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hold_repeat_ctrl_if.sv
// Button-request / increment-pulse bundle between the debouncers, the
// hold-repeat controller and the cooktime counters.
interface hold_repeat_ctrl_if;

    logic tick;
    logic enable;
    logic seconds_req;
    logic minutes_req;
    logic inc_seconds;
    logic inc_minutes;
    logic busy;
    logic fast_mode;

    modport master (
        output tick, enable, seconds_req, minutes_req,
        input  inc_seconds, inc_minutes, busy, fast_mode
    );

    modport slave (
        input  tick, enable, seconds_req, minutes_req,
        output inc_seconds, inc_minutes, busy, fast_mode
    );

endinterface

// File: rtl/hold_repeat_ctrl_repeat_timer.sv
// Tick-gated period counter: strobes expire on the tick that completes a period
// and restarts from zero; clear holds it at zero.
module repeat_timer #(
    parameter int CTR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 clear,
    input  logic [CTR_WIDTH-1:0] period,
    output logic                 expire
);

    localparam logic [CTR_WIDTH-1:0] ONE = CTR_WIDTH'(1);

    logic [CTR_WIDTH-1:0] count;

    assign expire = tick && (count == (period - ONE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick) begin
            count <= expire ? '0 : (count + ONE);
        end
    end

endmodule

// File: rtl/hold_repeat_ctrl.sv
// Hold-to-repeat arbiter for the minutes/seconds buttons: one immediate increment
// per press, then delayed slow auto-repeat, then fast auto-repeat, sharing one timer.
module hold_repeat_ctrl
    import hold_repeat_ctrl_pkg::*;
#(
    parameter int INITIAL_DELAY_TICKS = DEF_INITIAL_DELAY_TICKS,
    parameter int REPEAT_TICKS        = DEF_REPEAT_TICKS,
    parameter int FAST_AFTER          = DEF_FAST_AFTER,
    parameter int FAST_TICKS          = DEF_FAST_TICKS,
    parameter int CTR_WIDTH           = DEF_CTR_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    hold_repeat_ctrl_if.slave  bus
);

    localparam logic [CTR_WIDTH-1:0] P_INITIAL = CTR_WIDTH'(INITIAL_DELAY_TICKS);
    localparam logic [CTR_WIDTH-1:0] P_REPEAT  = CTR_WIDTH'(REPEAT_TICKS);
    localparam logic [CTR_WIDTH-1:0] P_FAST    = CTR_WIDTH'(FAST_TICKS);
    localparam logic [CTR_WIDTH-1:0] FAST_LIM  = CTR_WIDTH'(FAST_AFTER);
    localparam logic [CTR_WIDTH-1:0] ONE       = CTR_WIDTH'(1);

    state_t               state, state_n;
    owner_t               owner, owner_n;
    logic [CTR_WIDTH-1:0] rep_ctr, rep_n, rep_inc, period;
    logic                 owner_level, abort, expire, fire, timer_clear;
    logic                 inc_sec_q, inc_min_q, busy_q, fast_q;
    logic                 inc_sec_n, inc_min_n, busy_n, fast_n;

    always_comb begin
        case (state)
            ST_REPEAT: period = P_REPEAT;
            ST_FAST:   period = P_FAST;
            default:   period = P_INITIAL;
        endcase
    end

    repeat_timer #(
        .CTR_WIDTH (CTR_WIDTH)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .tick   (bus.tick),
        .clear  (timer_clear),
        .period (period),
        .expire (expire)
    );

    assign owner_level = owner_request(owner, bus.seconds_req, bus.minutes_req);
    assign abort       = (state != ST_IDLE) && (!bus.enable || !owner_level);
    assign rep_inc     = rep_ctr + ONE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= OWN_NONE;
            rep_ctr   <= '0;
            inc_sec_q <= 1'b0;
            inc_min_q <= 1'b0;
            busy_q    <= 1'b0;
            fast_q    <= 1'b0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            rep_ctr   <= rep_n;
            inc_sec_q <= inc_sec_n;
            inc_min_q <= inc_min_n;
            busy_q    <= busy_n;
            fast_q    <= fast_n;
        end
    end

    // Abort outranks a same-cycle expiry; the timer is held clear in IDLE so a
    // tick coinciding with the grant is never counted.
    always_comb begin
        state_n     = state;
        owner_n     = owner;
        rep_n       = rep_ctr;
        fire        = 1'b0;
        timer_clear = 1'b0;
        case (state)
            ST_IDLE: begin
                timer_clear = 1'b1;
                rep_n       = '0;
                owner_n     = OWN_NONE;
                if (bus.enable && (bus.seconds_req || bus.minutes_req)) begin
                    owner_n = bus.seconds_req ? OWN_SEC : OWN_MIN;
                    state_n = ST_INITIAL;
                    fire    = 1'b1;
                end
            end
            default: begin
                if (abort) begin
                    state_n     = ST_IDLE;
                    owner_n     = OWN_NONE;
                    rep_n       = '0;
                    timer_clear = 1'b1;
                end else if (expire) begin
                    fire = 1'b1;
                    case (state)
                        ST_INITIAL: begin
                            state_n = ST_REPEAT;
                            rep_n   = '0;
                        end
                        ST_REPEAT: begin
                            rep_n = rep_inc;
                            if (rep_inc == FAST_LIM) begin
                                state_n = ST_FAST;
                            end
                        end
                        default: rep_n = rep_ctr;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        inc_sec_n = fire && (owner_n == OWN_SEC);
        inc_min_n = fire && (owner_n == OWN_MIN);
        busy_n    = (state_n != ST_IDLE);
        fast_n    = (state_n == ST_FAST);
    end

    assign bus.inc_seconds = inc_sec_q;
    assign bus.inc_minutes = inc_min_q;
    assign bus.busy        = busy_q;
    assign bus.fast_mode   = fast_q;

endmodule

// File: tb/tb_hold_repeat_ctrl.sv
// Directed bench for hold_repeat_ctrl: tick every 10 clk, pulse times logged
// in clk cycles and in ticks relative to the first pulse of each hold.
module tb_hold_repeat_ctrl;

    logic clk = 1'b0;
    logic reset;

    hold_repeat_ctrl_if bus();

    hold_repeat_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc        = 0;
    int ticks_seen = 0;
    int phase      = 0;
    int sec_cyc[$];
    int sec_tk[$];
    int min_cyc[$];
    int min_tk[$];
    bit fast_seen;
    int fast_tk;

    initial begin
        bus.tick = 1'b0;
        forever begin
            @(negedge clk);
            phase    = (phase == 9) ? 0 : phase + 1;
            bus.tick = (phase == 9);
        end
    end

    // Outputs are sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.tick) ticks_seen = ticks_seen + 1;
        #1;
        if (bus.inc_seconds) begin
            sec_cyc.push_back(cyc);
            sec_tk.push_back(ticks_seen);
        end
        if (bus.inc_minutes) begin
            min_cyc.push_back(cyc);
            min_tk.push_back(ticks_seen);
        end
        if (bus.fast_mode && !fast_seen) begin
            fast_seen = 1'b1;
            fast_tk   = ticks_seen;
        end
    end

    task automatic clear_log();
        sec_cyc.delete();
        sec_tk.delete();
        min_cyc.delete();
        min_tk.delete();
        fast_seen = 1'b0;
        fast_tk   = 0;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        bus.enable      = 1'b1;
        bus.seconds_req = 1'b1;
        bus.minutes_req = 1'b0;
        clear_log();
        wait_clk(3);
        n_checks++;
        if ({bus.busy, bus.fast_mode, bus.inc_seconds, bus.inc_minutes} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0000",
                     {bus.busy, bus.fast_mode, bus.inc_seconds, bus.inc_minutes});
        end
        n_checks++;
        if (sec_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_no_pulse: got %0d pulses expected 0", sec_cyc.size());
        end
        bus.seconds_req = 1'b0;
        wait_clk(1);
        reset = 1'b0;
        wait_clk(2);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_single_press();
        int c0;
        clear_log();
        c0 = cyc;
        bus.seconds_req = 1'b1;
        wait_clk(1);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL press_busy: got %b expected 1", bus.busy);
        end
        wait_clk(199);
        bus.seconds_req = 1'b0;
        wait_clk(3);
        n_checks++;
        if (sec_cyc.size() !== 1) begin
            n_fail++;
            $display("FAIL press_count: got %0d pulses expected 1", sec_cyc.size());
        end
        if (sec_cyc.size() >= 1) begin
            n_checks++;
            if (sec_cyc[0] !== c0 + 1) begin
                n_fail++;
                $display("FAIL press_latency: got cycle %0d expected %0d", sec_cyc[0], c0 + 1);
            end
        end
        n_checks++;
        if (min_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL press_minutes_quiet: got %0d pulses expected 0", min_cyc.size());
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL press_release_busy: got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_slow_repeat();
        int exp_tk[$];
        exp_tk = '{0, 50, 70, 90, 110, 130};
        clear_log();
        bus.minutes_req = 1'b1;
        wait_clk(1450);
        bus.minutes_req = 1'b0;
        wait_clk(3);
        n_checks++;
        if (min_tk.size() !== exp_tk.size()) begin
            n_fail++;
            $display("FAIL slow_count: got %0d pulses expected %0d", min_tk.size(), exp_tk.size());
        end
        for (int i = 1; i < exp_tk.size(); i++) begin
            if (i < min_tk.size()) begin
                n_checks++;
                if (min_tk[i] - min_tk[0] !== exp_tk[i]) begin
                    n_fail++;
                    $display("FAIL slow_pulse_%0d: got tick %0d expected %0d",
                             i, min_tk[i] - min_tk[0], exp_tk[i]);
                end
            end
        end
        n_checks++;
        if (fast_seen !== 1'b0 || sec_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL slow_side_effects: got fast_seen=%b sec_pulses=%0d expected 0 0",
                     fast_seen, sec_cyc.size());
        end
    endtask

    task automatic test_fast_repeat();
        int exp_tk[$];
        exp_tk.push_back(0);
        exp_tk.push_back(50);
        for (int k = 1; k <= 10; k++) exp_tk.push_back(50 + 20 * k);
        for (int k = 1; k <= 9; k++) exp_tk.push_back(250 + 5 * k);
        clear_log();
        bus.seconds_req = 1'b1;
        wait_clk(2980);
        bus.seconds_req = 1'b0;
        wait_clk(3);
        n_checks++;
        if (sec_tk.size() !== 21) begin
            n_fail++;
            $display("FAIL fast_count: got %0d pulses expected 21", sec_tk.size());
        end
        for (int i = 1; i < exp_tk.size(); i++) begin
            if (i < sec_tk.size()) begin
                n_checks++;
                if (sec_tk[i] - sec_tk[0] !== exp_tk[i]) begin
                    n_fail++;
                    $display("FAIL fast_pulse_%0d: got tick %0d expected %0d",
                             i, sec_tk[i] - sec_tk[0], exp_tk[i]);
                end
            end
        end
        if (sec_tk.size() >= 1) begin
            n_checks++;
            if (!fast_seen || (fast_tk - sec_tk[0]) !== 250) begin
                n_fail++;
                $display("FAIL fast_mode_rise: got seen=%b tick %0d expected tick 250",
                         fast_seen, fast_tk - sec_tk[0]);
            end
        end
        n_checks++;
        if (bus.fast_mode !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fast_release: got fast=%b busy=%b expected 0 0", bus.fast_mode, bus.busy);
        end
    endtask

    task automatic test_priority_handover();
        int c_rel;
        clear_log();
        bus.seconds_req = 1'b1;
        bus.minutes_req = 1'b1;
        wait_clk(600);
        n_checks++;
        if (sec_cyc.size() !== 2 || min_cyc.size() !== 0) begin
            n_fail++;
            $display("FAIL prio_owner: got sec=%0d min=%0d expected sec=2 min=0",
                     sec_cyc.size(), min_cyc.size());
        end
        bus.seconds_req = 1'b0;
        c_rel = cyc;
        wait_clk(50);
        n_checks++;
        if (min_cyc.size() !== 1) begin
            n_fail++;
            $display("FAIL handover_count: got %0d pulses expected 1", min_cyc.size());
        end
        if (min_cyc.size() >= 1) begin
            n_checks++;
            if (min_cyc[0] !== c_rel + 2) begin
                n_fail++;
                $display("FAIL handover_latency: got cycle %0d expected %0d", min_cyc[0], c_rel + 2);
            end
        end
        n_checks++;
        if (sec_cyc.size() !== 2) begin
            n_fail++;
            $display("FAIL handover_sec_quiet: got %0d pulses expected 2", sec_cyc.size());
        end
        bus.minutes_req = 1'b0;
        wait_clk(3);
    endtask

    task automatic test_enable_drop();
        int c_e;
        clear_log();
        bus.seconds_req = 1'b1;
        wait_clk(800);
        n_checks++;
        if (sec_cyc.size() !== 3) begin
            n_fail++;
            $display("FAIL endrop_before: got %0d pulses expected 3", sec_cyc.size());
        end
        bus.enable = 1'b0;
        wait_clk(1);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL endrop_busy: got %b expected 0", bus.busy);
        end
        wait_clk(300);
        n_checks++;
        if (sec_cyc.size() !== 3) begin
            n_fail++;
            $display("FAIL endrop_quiet: got %0d pulses expected 3", sec_cyc.size());
        end
        clear_log();
        c_e = cyc;
        bus.enable = 1'b1;
        wait_clk(600);
        n_checks++;
        if (sec_cyc.size() !== 2) begin
            n_fail++;
            $display("FAIL enreturn_count: got %0d pulses expected 2", sec_cyc.size());
        end
        if (sec_cyc.size() >= 2) begin
            n_checks++;
            if (sec_cyc[0] !== c_e + 1 || (sec_tk[1] - sec_tk[0]) !== 50) begin
                n_fail++;
                $display("FAIL enreturn_timing: got cycle %0d gap %0d expected cycle %0d gap 50",
                         sec_cyc[0], sec_tk[1] - sec_tk[0], c_e + 1);
            end
        end
        bus.seconds_req = 1'b0;
        wait_clk(3);
    endtask

    task automatic test_async_reset();
        int c_r;
        clear_log();
        bus.seconds_req = 1'b1;
        wait_clk(2700);
        n_checks++;
        if (bus.fast_mode !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre: got fast=%b busy=%b expected 1 1", bus.fast_mode, bus.busy);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.fast_mode, bus.inc_seconds, bus.inc_minutes} !== 4'b0000) begin
            n_fail++;
            $display("FAIL arst_immediate: got %b expected 0000",
                     {bus.busy, bus.fast_mode, bus.inc_seconds, bus.inc_minutes});
        end
        wait_clk(3);
        clear_log();
        c_r = cyc;
        reset = 1'b0;
        wait_clk(1);
        n_checks++;
        if (sec_cyc.size() !== 1 || bus.busy !== 1'b1 || bus.fast_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_regrant: got pulses=%0d busy=%b fast=%b expected 1 1 0",
                     sec_cyc.size(), bus.busy, bus.fast_mode);
        end
        if (sec_cyc.size() >= 1) begin
            n_checks++;
            if (sec_cyc[0] !== c_r + 1) begin
                n_fail++;
                $display("FAIL arst_latency: got cycle %0d expected %0d", sec_cyc[0], c_r + 1);
            end
        end
        bus.seconds_req = 1'b0;
        wait_clk(3);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1, "time limit reached");
    end

    initial begin
        test_reset();
        test_single_press();
        test_slow_repeat();
        test_fast_repeat();
        test_priority_handover();
        test_enable_drop();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
